// File: rtl/video_pkg.sv
// Shared state encoding, error-bit indices and helpers for video_capture.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  localparam int ERR_EOL_EARLY = 0;
  localparam int ERR_EOL_LATE  = 1;
  localparam int ERR_SOF_MID   = 2;

  localparam int POSW  = 13;
  localparam int ADDRW = 17;

  function automatic logic [POSW-1:0] clamp_pos(input logic [POSW-1:0] v,
                                                input logic [POSW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/video_capture_win.sv
// Capture-window hit test and row-major write address pointer.
// The origin is latched (clamped) on each start-of-frame beat.
module video_capture_win
  import video_pkg::*;
#(
  parameter int SCRW = 1920,
  parameter int SCRH = 1080,
  parameter int IMGW = 320,
  parameter int IMGH = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sof,
  input  logic             i_pix,
  input  logic [POSW-1:0]  i_x,
  input  logic [POSW-1:0]  i_y,
  input  logic [POSW-1:0]  i_winx,
  input  logic [POSW-1:0]  i_winy,
  output logic             o_hit,
  output logic [ADDRW-1:0] o_addr
);

  localparam logic [POSW-1:0] WX_MAX = POSW'(SCRW - IMGW);
  localparam logic [POSW-1:0] WY_MAX = POSW'(SCRH - IMGH);

  logic [POSW-1:0]  r_wx;
  logic [POSW-1:0]  r_wy;
  logic [ADDRW-1:0] r_ptr;

  logic [POSW-1:0]  w_wx;
  logic [POSW-1:0]  w_wy;
  logic [POSW:0]    w_xend;
  logic [POSW:0]    w_yend;
  logic             w_in;
  logic [ADDRW-1:0] w_addr;

  // The SOF beat is itself pixel (0,0), so it must see the freshly clamped origin.
  always_comb begin
    w_wx   = i_sof ? clamp_pos(i_winx, WX_MAX) : r_wx;
    w_wy   = i_sof ? clamp_pos(i_winy, WY_MAX) : r_wy;
    w_xend = {1'b0, w_wx} + (POSW+1)'(IMGW);
    w_yend = {1'b0, w_wy} + (POSW+1)'(IMGH);
    w_in   = (i_x >= w_wx) && ({1'b0, i_x} < w_xend) &&
             (i_y >= w_wy) && ({1'b0, i_y} < w_yend);
    w_addr = i_sof ? {ADDRW{1'b0}} : r_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wx  <= {POSW{1'b0}};
      r_wy  <= {POSW{1'b0}};
      r_ptr <= {ADDRW{1'b0}};
    end else begin
      if (i_sof) begin
        r_wx <= w_wx;
        r_wy <= w_wy;
      end else begin
        r_wx <= r_wx;
        r_wy <= r_wy;
      end
      if (i_pix && w_in) begin
        r_ptr <= w_addr + ADDRW'(1);
      end else if (i_sof) begin
        r_ptr <= {ADDRW{1'b0}};
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign o_hit  = i_pix && w_in;
  assign o_addr = w_addr;

endmodule

// File: rtl/video_capture.sv
// AXI-stream video frame capture into a BRAM window buffer.
// Define VIDEO_CAPTURE_CHECK_EN to build the sticky line/frame error detection.
module video_capture
  import video_pkg::*;
#(
  parameter int DATAW = 24,
  parameter int SCRW  = 1920,
  parameter int SCRH  = 1080,
  parameter int IMGW  = 320,
  parameter int IMGH  = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_err,
  input  logic [12:0]      winx,
  input  logic [12:0]      winy,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             bram_we_o,
  output logic [16:0]      bram_addr_o,
  output logic [DATAW-1:0] bram_data_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o,
  output logic             busy_o,
  output logic [2:0]       err_o
);

  localparam logic [POSW-1:0] X_LAST = POSW'(SCRW - 1);
  localparam logic [POSW-1:0] Y_LAST = POSW'(SCRH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_tready;
  logic             w_busy;

  logic [POSW-1:0]  r_x;
  logic [POSW-1:0]  r_y;
  logic             r_we;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_data;
  logic             r_done;
  logic [15:0]      r_cnt;
  logic [2:0]       r_err;

  logic             w_accept;
  logic             w_sof;
  logic             w_pix;
  logic [POSW-1:0]  w_px;
  logic [POSW-1:0]  w_py;
  logic             w_last_col;
  logic             w_eol;
  logic             w_frame_end;
  logic [2:0]       w_err_set;
  logic             w_hit;
  logic [ADDRW-1:0] w_addr;

  // Beat classification and current pixel position (SOF beats are pixel 0,0).
  always_comb begin
    w_accept    = s_axis_tvalid && w_tready;
    w_sof       = w_accept && s_axis_tuser &&
                  ((r_state == ST_ACTIVE) || ((r_state == ST_WAIT_SOF) && en));
    w_pix       = w_sof || (w_accept && (r_state == ST_ACTIVE));
    w_px        = w_sof ? {POSW{1'b0}} : r_x;
    w_py        = w_sof ? {POSW{1'b0}} : r_y;
    w_last_col  = (w_px == X_LAST);
    w_eol       = s_axis_tlast || w_last_col;
    w_frame_end = w_pix && w_eol && (w_py == Y_LAST);
  end

  // Error events; without checking the sticky bits never set.
  always_comb begin
    w_err_set = 3'b000;
`ifdef VIDEO_CAPTURE_CHECK_EN
    w_err_set[ERR_EOL_EARLY] = w_pix && s_axis_tlast && !w_last_col;
    w_err_set[ERR_EOL_LATE]  = w_pix && w_last_col && !s_axis_tlast;
    w_err_set[ERR_SOF_MID]   = w_sof && (r_state == ST_ACTIVE);
`else
    w_err_set = 3'b000;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; disabling mid-frame waits for the frame to end.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) w_next = ST_WAIT_SOF;
        else    w_next = ST_IDLE;
      end
      ST_WAIT_SOF: begin
        if (!en)             w_next = ST_IDLE;
        else if (w_frame_end) w_next = ST_WAIT_SOF;
        else if (w_sof)       w_next = ST_ACTIVE;
        else                  w_next = ST_WAIT_SOF;
      end
      ST_ACTIVE: begin
        if (w_frame_end) w_next = en ? ST_WAIT_SOF : ST_IDLE;
        else             w_next = ST_ACTIVE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_tready = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      ST_IDLE:     begin w_tready = 1'b0; w_busy = 1'b0; end
      ST_WAIT_SOF: begin w_tready = 1'b1; w_busy = 1'b0; end
      ST_ACTIVE:   begin w_tready = 1'b1; w_busy = 1'b1; end
      default:     begin w_tready = 1'b0; w_busy = 1'b0; end
    endcase
  end

  video_capture_win #(
    .SCRW (SCRW),
    .SCRH (SCRH),
    .IMGW (IMGW),
    .IMGH (IMGH)
  ) u_win (
    .clk    (clk),
    .rst    (rst),
    .i_sof  (w_sof),
    .i_pix  (w_pix),
    .i_x    (w_px),
    .i_y    (w_py),
    .i_winx (winx),
    .i_winy (winy),
    .o_hit  (w_hit),
    .o_addr (w_addr)
  );

  // Position tracking, registered BRAM write, frame counter and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= {POSW{1'b0}};
      r_y    <= {POSW{1'b0}};
      r_we   <= 1'b0;
      r_addr <= {ADDRW{1'b0}};
      r_data <= {DATAW{1'b0}};
      r_done <= 1'b0;
      r_cnt  <= 16'd0;
      r_err  <= 3'b000;
    end else begin
      if (w_pix && w_eol) begin
        r_x <= {POSW{1'b0}};
        r_y <= (w_py == Y_LAST) ? {POSW{1'b0}} : w_py + POSW'(1);
      end else if (w_pix) begin
        r_x <= w_px + POSW'(1);
        r_y <= w_py;
      end else begin
        r_x <= r_x;
        r_y <= r_y;
      end
      r_we <= w_hit;
      if (w_hit) begin
        r_addr <= w_addr;
        r_data <= s_axis_tdata;
      end else begin
        r_addr <= r_addr;
        r_data <= r_data;
      end
      r_done <= w_frame_end;
      if (w_frame_end) r_cnt <= r_cnt + 16'd1;
      else             r_cnt <= r_cnt;
      r_err <= (clr_err ? 3'b000 : r_err) | w_err_set;
    end
  end

  assign s_axis_tready = w_tready;
  assign busy_o        = w_busy;
  assign bram_we_o     = r_we;
  assign bram_addr_o   = r_addr;
  assign bram_data_o   = r_data;
  assign frame_done_o  = r_done;
  assign frame_cnt_o   = r_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_video_capture.sv
// Self-checking bench for video_capture: coordinate-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_video_capture;

  localparam int DATAW = 24;
  localparam int SCRW  = 16;
  localparam int SCRH  = 8;
  localparam int IMGW  = 4;
  localparam int IMGH  = 2;
`ifdef VIDEO_CAPTURE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [12:0] winx = 13'd0, winy = 13'd0;
  logic [23:0] tdata = 24'd0;
  logic tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic tready, we, done, busy;
  logic [16:0] addr;
  logic [23:0] data;
  logic [15:0] cnt;
  logic [2:0]  err;

  video_capture #(.DATAW(DATAW), .SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .winx(winx), .winy(winy),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .bram_we_o(we), .bram_addr_o(addr), .bram_data_o(data),
    .frame_done_o(done), .frame_cnt_o(cnt), .busy_o(busy), .err_o(err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (screen-coordinate level) ----------------
  int m_mode = 0;                 // 0 idle, 1 waiting for SOF, 2 capturing
  int m_x = 0, m_y = 0, m_wx = 0, m_wy = 0, m_nwr = 0, m_cnt = 0;
  logic [2:0] m_err = 3'b000;
  bit e_we = 0, e_done = 0;
  int e_addr = 0;
  logic [23:0] e_data = 24'd0;
  bit mv_acc, mv_pix;
  logic [2:0] mv_es;

  task automatic model_new_frame();
    m_x = 0; m_y = 0; m_nwr = 0;
    m_wx = (int'(winx) > SCRW - IMGW) ? SCRW - IMGW : int'(winx);
    m_wy = (int'(winy) > SCRH - IMGH) ? SCRH - IMGH : int'(winy);
    m_mode = 2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_x = 0; m_y = 0; m_nwr = 0; m_cnt = 0; m_err = 3'b000;
      e_we = 0; e_done = 0;
    end else begin
      mv_acc = tvalid && (m_mode != 0);
      mv_pix = 0; mv_es = 3'b000; e_we = 0; e_done = 0;
      if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!en) m_mode = 0;
        else if (mv_acc && tuser) begin model_new_frame(); mv_pix = 1; end
      end else if (mv_acc) begin
        mv_pix = 1;
        if (tuser) begin mv_es[2] = 1'b1; model_new_frame(); end
      end
      if (mv_pix) begin
        if (m_x >= m_wx && m_x < m_wx + IMGW && m_y >= m_wy && m_y < m_wy + IMGH) begin
          e_we = 1; e_addr = m_nwr; e_data = tdata; m_nwr++;
        end
        if (tlast || m_x == SCRW - 1) begin
          if (tlast && m_x != SCRW - 1) mv_es[0] = 1'b1;
          if (!tlast) mv_es[1] = 1'b1;
          m_x = 0;
          if (m_y == SCRH - 1) begin
            e_done = 1; m_cnt = (m_cnt + 1) % 65536; m_y = 0; m_mode = en ? 1 : 0;
          end else begin
            m_y++;
          end
        end else begin
          m_x++;
        end
      end
      m_err = CHK ? ((clr_err ? 3'b000 : m_err) | mv_es) : 3'b000;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [16:0] log_addr[$];
  logic [23:0] log_data[$];
  int done_pulses = 0;

  always @(negedge clk) begin
    chk("tready", tready, m_mode != 0);
    chk("busy", busy, m_mode == 2);
    chk("we", we, e_we);
    if (e_we) begin
      chk("addr", addr, e_addr);
      chk("data", data, e_data);
    end
    chk("done", done, e_done);
    chk("cnt", cnt, m_cnt);
    chk("err", err, m_err);
    if (we) begin log_addr.push_back(addr); log_data.push_back(data); end
    if (done) done_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [23:0] pixv(input int f, input int x, input int y);
    return {f[7:0], y[7:0], x[7:0]};
  endfunction

  task automatic beat(input logic [23:0] d, input logic u, input logic l);
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    @(posedge clk); #2;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_line(input int f, input int y, input int len, input bit sof);
    for (int x = 0; x < len; x++) beat(pixv(f, x, y), sof && (x == 0), x == len - 1);
  endtask

  task automatic send_frame(input int f);
    for (int y = 0; y < SCRH; y++) send_line(f, y, SCRW, y == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete();
  endtask

  task automatic check_window(input string name, input int f, input int wx, input int wy);
    chk({name, "_nwr"}, log_addr.size(), IMGW * IMGH);
    for (int i = 0; i < IMGW * IMGH && i < log_addr.size(); i++) begin
      chk({name, "_addr"}, log_addr[i], i);
      chk({name, "_data"}, log_data[i], pixv(f, wx + i % IMGW, wy + i / IMGW));
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int g;
  bit rdy;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tready", tready, 0); chk("rst_we", we, 0); chk("rst_addr", addr, 0);
    chk("rst_data", data, 0); chk("rst_done", done, 0); chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    rst = 1'b0;
    winx = 13'd2; winy = 13'd3;
    idle(1);
    chk("idle_tready", tready, 0);
    en = 1'b1;
    idle(1);
    chk("wait_tready", tready, 1);

    // Beats before SOF are discarded.
    clear_log();
    for (int i = 0; i < 3; i++) beat(24'hABCD00 + 24'(i), 1'b0, 1'b0);
    idle(2);
    chk("presof_nwr", log_addr.size(), 0);
    chk("presof_tready", tready, 1);
    chk("presof_busy", busy, 0);

    // Clean frame.
    clear_log(); done_pulses = 0;
    send_frame(1);
    idle(3);
    check_window("clean", 1, 2, 3);
    chk("clean_cnt", cnt, 1);
    chk("clean_pulses", done_pulses, 1);
    chk("clean_busy", busy, 0);

    // Early tlast at x=9 on line 2.
    clear_log();
    send_line(2, 0, SCRW, 1); send_line(2, 1, SCRW, 0); send_line(2, 2, 10, 0);
    for (int y = 3; y < SCRH; y++) send_line(2, y, SCRW, 0);
    idle(3);
    check_window("early", 2, 2, 3);
    chk("early_err", err, CHK ? 3'b001 : 3'b000);
    chk("early_cnt", cnt, 2);
    pulse_clr();
    chk("clr_err", err, 0);

    // SOF mid-frame at (5,4) restarts the frame.
    clear_log();
    for (int y = 0; y < 4; y++) send_line(3, y, SCRW, y == 0);
    for (int x = 0; x < 5; x++) beat(pixv(3, x, 4), 1'b0, 1'b0);
    chk("abort_cnt", cnt, 2);
    send_frame(4);
    idle(3);
    chk("abort_nwr", log_addr.size(), 15);
    chk("abort_last_addr", log_addr[6], 6);
    chk("abort_last_data", log_data[6], pixv(3, 4, 4));
    chk("abort_restart_addr", log_addr[7], 0);
    chk("abort_restart_data", log_data[7], pixv(4, 2, 3));
    chk("abort_cnt2", cnt, 3);
    chk("abort_err", err, CHK ? 3'b100 : 3'b000);
    pulse_clr();

    // Window origin clamped.
    winx = 13'd20; winy = 13'd20;
    clear_log();
    send_frame(5);
    idle(3);
    check_window("clamp", 5, 12, 6);
    chk("clamp_cnt", cnt, 4);

    // Reset at (3,3).
    winx = 13'd2; winy = 13'd3;
    clear_log();
    for (int y = 0; y < 3; y++) send_line(6, y, SCRW, y == 0);
    for (int x = 0; x < 3; x++) beat(pixv(6, x, 3), 1'b0, 1'b0);
    tvalid = 1'b1; tdata = pixv(6, 3, 3);
    #1 rst = 1'b1;
    #1;
    chk("mrst_tready", tready, 0); chk("mrst_we", we, 0); chk("mrst_addr", addr, 0);
    chk("mrst_data", data, 0); chk("mrst_done", done, 0); chk("mrst_cnt", cnt, 0);
    chk("mrst_busy", busy, 0); chk("mrst_err", err, 0);
    @(posedge clk); #2;
    rst = 1'b0; tvalid = 1'b0;
    clear_log();
    for (int x = 4; x < SCRW; x++) beat(pixv(6, x, 3), 1'b0, x == SCRW - 1);
    for (int y = 4; y < SCRH; y++) send_line(6, y, SCRW, 0);
    idle(2);
    chk("mrst_nwr", log_addr.size(), 0);
    chk("mrst_cnt2", cnt, 0);
    send_frame(7);
    idle(3);
    check_window("post_rst", 7, 2, 3);
    chk("post_rst_cnt", cnt, 1);

    // Randomized traffic against the model.
    g = 0;
    for (int c = 0; c < 5000; c++) begin
      if (en) begin if ($urandom_range(0, 299) == 0) en = 1'b0; end
      else if ($urandom_range(0, 4) == 0) en = 1'b1;
      clr_err = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) begin
        winx = 13'($urandom_range(0, 20)); winy = 13'($urandom_range(0, 10));
      end
      tvalid = ($urandom_range(0, 3) != 0);
      tuser  = tvalid && ((g % (SCRW * SCRH)) == 0 || $urandom_range(0, 599) == 0);
      tlast  = tvalid && (((g % SCRW) == SCRW - 1 && $urandom_range(0, 19) != 0) ||
                          $urandom_range(0, 79) == 0);
      tdata  = 24'($urandom);
      rdy = tready;
      @(posedge clk); #2;
      if (tvalid && rdy) begin
        if (tlast) g = (g / SCRW + 1) * SCRW;
        else       g++;
      end
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; clr_err = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have parameter DATAW, default 24, meaning pixel width.
REQ-002 SHALL have parameter SCRW, default 1920, meaning input line length in pixels.
REQ-003 SHALL have parameter SCRH, default 1080, meaning input lines per frame.
REQ-004 SHALL have parameter IMGW, default 320, meaning capture window width.
REQ-005 SHALL have parameter IMGH, default 240, meaning capture window height; IMGW*IMGH <= 2^17.
REQ-006 SHALL have port clk  in  1  single clock for all logic.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports en, clr_err  in  1 each  capture enable; sticky-error clear.
REQ-009 SHALL have ports winx, winy  in  13 each  window origin in screen pixels.
REQ-010 SHALL have ports s_axis_tdata (DATAW), s_axis_tvalid, s_axis_tuser (SOF), s_axis_tlast (EOL)  in, and s_axis_tready  out  1.
REQ-011 SHALL have ports bram_we_o  out  1, bram_addr_o  out  17, bram_data_o  out  DATAW.
REQ-012 SHALL have ports frame_done_o  out  1 (pulse), frame_cnt_o  out  16, busy_o  out  1, err_o  out  3 ({sof_mid, eol_late, eol_early}).

Function
REQ-013 SHALL implement states IDLE, WAIT_SOF, ACTIVE.
REQ-014 SHALL be in IDLE after reset; IDLE->WAIT_SOF when en=1; WAIT_SOF->IDLE when en=0; en=0 in ACTIVE takes effect only at frame end.
REQ-015 SHALL drive s_axis_tready=1 in WAIT_SOF and ACTIVE, 0 in IDLE; a beat is accepted when tvalid&&tready.
REQ-016 SHALL discard accepted beats in WAIT_SOF until tuser=1; that beat is pixel (0,0) and moves the FSM to ACTIVE.
REQ-017 SHALL latch window origin at each SOF, clamped: wx=min(winx,SCRW-IMGW), wy=min(winy,SCRH-IMGH).
REQ-018 SHALL track x in 0..SCRW-1 and y in 0..SCRH-1, incrementing x per accepted beat, wrapping x to 0 and incrementing y at end of line.
REQ-019 SHALL write a pixel when wx<=x<wx+IMGW and wy<=y<wy+IMGH, using an address pointer reset to 0 at SOF and incremented per written pixel (row-major, no multiplier).
REQ-020 SHALL register the write: beat accepted in cycle N gives bram_we_o=1 with addr/data in cycle N+1; bram_we_o=0 otherwise.
REQ-021 SHALL treat end of line as tlast=1 or x=SCRW-1, whichever comes first.
REQ-022 SHALL set err_o[0] on tlast with x<SCRW-1, and err_o[1] on x=SCRW-1 without tlast; the line ends in both cases.
REQ-023 SHALL, on tuser=1 in ACTIVE, set err_o[2] and restart the frame at (0,0) with that beat as pixel (0,0); the aborted frame is not counted.
REQ-024 SHALL, on end of line with y=SCRH-1, pulse frame_done_o one cycle, increment frame_cnt_o (wraps 0xFFFF->0), go to WAIT_SOF (IDLE if en=0).
REQ-025 SHALL hold err_o bits sticky until clr_err=1; simultaneous set and clear gives set.
REQ-026 SHALL drive busy_o=1 only in ACTIVE.

Reset
REQ-027 SHALL, on rst=1, asynchronously force IDLE, tready=0, bram_we_o=0, bram_addr_o=0, bram_data_o=0, frame_done_o=0, frame_cnt_o=0, busy_o=0, err_o=0, x=y=0.
REQ-028 SHALL, on reset mid-frame, abandon the frame with no further writes; the next capture waits for a fresh SOF.

Configuration
REQ-029 SHALL honour macro VIDEO_CAPTURE_CHECK_EN: defined, REQ-022/023 error logic present; undefined, err_o tied 0, line end by tlast or x=SCRW-1 (REQ-021 unchanged), tuser in ACTIVE still restarts the frame.

Structure
REQ-030 SHALL place the state enum and the error-bit index constants in shared package video_pkg.
REQ-031 SHALL instantiate one sub-module video_capture_win (window compare and address pointer).

Verification
REQ-032 SHALL use SCRW=16, SCRH=8, IMGW=4, IMGH=2, winx=2, winy=3, full-rate tvalid: clean frame -> 8 writes, addr 0..7, data = pixels (2..5,3) then (2..5,4); frame_done_o pulse; frame_cnt_o=1.
REQ-033 SHALL test three beats with tuser=0 before SOF -> discarded, no writes, tready=1.
REQ-034 SHALL test tlast at x=9 on line 2 -> err_o=3'b001, next beat at (0,3), frame still completes.
REQ-035 SHALL test tuser at (5,4) -> err_o=3'b100, addr restarts at 0, frame_cnt_o unchanged until next full frame.
REQ-036 SHALL test winx=20, winy=20 -> clamped to wx=12, wy=6, 8 writes from (12,6).
REQ-037 SHALL test rst asserted at (3,3) -> all outputs zero within same cycle, no writes until next SOF after en.
